// File: rtl/alu_sequencer.sv
// alu_sequencer: assembles BCD operands/opcode from keypad events and sequences the 9-bit sign+BCD ALU.
// Define ALU_SEQ_CHAIN_EN to let an OPER key in SHOW chain the held result in as the next operand A.
module alu_sequencer #(
  parameter int unsigned ALU_LAT = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key_valid,
  output logic       o_key_ready,
  input  logic [1:0] i_key_type,
  input  logic [3:0] i_key_data,
  output logic [8:0] o_alu_op,
  output logic       o_alu_assign_op1,
  output logic       o_alu_assign_op2,
  output logic [2:0] o_alu_opcode,
  output logic       o_alu_en,
  input  logic [8:0] i_alu_result,
  output logic [8:0] o_disp_value,
  output logic       o_result_valid,
  output logic       o_busy,
  output logic       o_err
);

  localparam int unsigned OP_W  = 9;
  localparam int unsigned CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [1:0] KEY_DIGIT  = 2'b00;
  localparam logic [1:0] KEY_OPER   = 2'b01;
  localparam logic [1:0] KEY_EQUALS = 2'b10;

  localparam logic [2:0] OPC_ADD = 3'b001;
  localparam logic [2:0] OPC_SUB = 3'b010;

  typedef enum logic [2:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_CAPTURE,
    S_SHOW
  } state_t;

  state_t            r_state, w_state_nx;
  logic [OP_W-1:0]   r_op_a, w_op_a_nx;
  logic [OP_W-1:0]   r_op_b, w_op_b_nx;
  logic [OP_W-1:0]   r_result, w_result_nx;
  logic [1:0]        r_a_cnt, w_a_cnt_nx;
  logic [1:0]        r_b_cnt, w_b_cnt_nx;
  logic [2:0]        r_opcode, w_opcode_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic              r_err, w_err_nx;

  logic              r_key_ready, w_key_ready_nx;
  logic [OP_W-1:0]   r_alu_op, w_alu_op_nx;
  logic              r_assign_op1, w_assign_op1_nx;
  logic              r_assign_op2, w_assign_op2_nx;
  logic [2:0]        r_alu_opcode, w_alu_opcode_nx;
  logic              r_alu_en, w_alu_en_nx;
  logic [OP_W-1:0]   r_disp, w_disp_nx;
  logic              r_result_valid, w_result_valid_nx;
  logic              r_busy, w_busy_nx;

  logic              w_accept;
  logic              w_digit_ok;
  logic              w_opc_ok;
  logic              w_do_clear;

  assign w_accept   = i_key_valid && r_key_ready;
  assign w_digit_ok = (i_key_data < 4'd10);
  assign w_opc_ok   = (i_key_data[2:0] == OPC_ADD) || (i_key_data[2:0] == OPC_SUB);

  // Next-state, datapath and registered-output decode
  always_comb begin
    w_state_nx  = r_state;
    w_op_a_nx   = r_op_a;
    w_op_b_nx   = r_op_b;
    w_result_nx = r_result;
    w_a_cnt_nx  = r_a_cnt;
    w_b_cnt_nx  = r_b_cnt;
    w_opcode_nx = r_opcode;
    w_cnt_nx    = r_cnt;
    w_err_nx    = r_err;
    w_do_clear  = 1'b0;

    case (r_state)
      S_ENTER_A: begin
        if (w_accept) begin
          case (i_key_type)
            KEY_DIGIT: begin
              if (!w_digit_ok) begin
                w_err_nx = 1'b1;
              end else if (r_a_cnt < 2'd2) begin
                w_op_a_nx  = {1'b0, r_op_a[3:0], i_key_data};
                w_a_cnt_nx = r_a_cnt + 2'd1;
              end
            end
            KEY_OPER: begin
              if (w_opc_ok) begin
                w_opcode_nx = i_key_data[2:0];
                w_op_b_nx   = '0;
                w_b_cnt_nx  = '0;
                w_state_nx  = S_ENTER_B;
              end else begin
                w_err_nx = 1'b1;
              end
            end
            KEY_EQUALS: w_state_nx = S_ENTER_A;
            default:    w_do_clear = 1'b1;
          endcase
        end
      end

      S_ENTER_B: begin
        if (w_accept) begin
          case (i_key_type)
            KEY_DIGIT: begin
              if (!w_digit_ok) begin
                w_err_nx = 1'b1;
              end else if (r_b_cnt < 2'd2) begin
                w_op_b_nx  = {1'b0, r_op_b[3:0], i_key_data};
                w_b_cnt_nx = r_b_cnt + 2'd1;
              end
            end
            KEY_OPER: begin
              // Opcode may only be revised before operand B has started
              if (r_b_cnt == 2'd0) begin
                if (w_opc_ok) begin
                  w_opcode_nx = i_key_data[2:0];
                end else begin
                  w_err_nx = 1'b1;
                end
              end
            end
            KEY_EQUALS: w_state_nx = S_LOAD_A;
            default:    w_do_clear = 1'b1;
          endcase
        end
      end

      S_LOAD_A: w_state_nx = S_LOAD_B;

      S_LOAD_B: begin
        w_cnt_nx   = CNT_W'(ALU_LAT - 1);
        w_state_nx = S_EXEC;
      end

      S_EXEC: begin
        if (r_cnt == '0) begin
          w_state_nx = S_CAPTURE;
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end

      S_CAPTURE: begin
        w_result_nx = i_alu_result;
        w_state_nx  = S_SHOW;
      end

      S_SHOW: begin
        if (w_accept) begin
          case (i_key_type)
            KEY_DIGIT: begin
              if (w_digit_ok) begin
                w_op_a_nx  = {5'b0, i_key_data};
                w_a_cnt_nx = 2'd1;
                w_op_b_nx  = '0;
                w_b_cnt_nx = '0;
                w_state_nx = S_ENTER_A;
              end else begin
                w_err_nx = 1'b1;
              end
            end
            KEY_OPER: begin
`ifdef ALU_SEQ_CHAIN_EN
              // Held result (sign included) becomes operand A of the next operation
              if (w_opc_ok) begin
                w_op_a_nx   = r_result;
                w_opcode_nx = i_key_data[2:0];
                w_op_b_nx   = '0;
                w_b_cnt_nx  = '0;
                w_state_nx  = S_ENTER_B;
              end else begin
                w_err_nx = 1'b1;
              end
`else
              w_state_nx = S_SHOW;
`endif
            end
            KEY_EQUALS: w_state_nx = S_SHOW;
            default:    w_do_clear = 1'b1;
          endcase
        end
      end

      default: w_state_nx = S_ENTER_A;
    endcase

    if (w_do_clear) begin
      w_state_nx  = S_ENTER_A;
      w_op_a_nx   = '0;
      w_op_b_nx   = '0;
      w_result_nx = '0;
      w_a_cnt_nx  = '0;
      w_b_cnt_nx  = '0;
      w_opcode_nx = '0;
      w_err_nx    = 1'b0;
    end

    w_key_ready_nx    = (w_state_nx == S_ENTER_A) || (w_state_nx == S_ENTER_B) ||
                        (w_state_nx == S_SHOW);
    w_busy_nx         = !w_key_ready_nx;
    w_assign_op1_nx   = (w_state_nx == S_LOAD_A);
    w_assign_op2_nx   = (w_state_nx == S_LOAD_B);
    w_alu_en_nx       = (w_state_nx == S_EXEC);
    w_result_valid_nx = (r_state == S_CAPTURE);

    w_alu_op_nx = '0;
    if (w_assign_op1_nx) begin
      w_alu_op_nx = w_op_a_nx;
    end else if (w_assign_op2_nx) begin
      w_alu_op_nx = w_op_b_nx;
    end

    w_alu_opcode_nx = '0;
    if ((w_state_nx == S_LOAD_B) || (w_state_nx == S_EXEC) || (w_state_nx == S_CAPTURE)) begin
      w_alu_opcode_nx = w_opcode_nx;
    end

    case (w_state_nx)
      S_ENTER_A: w_disp_nx = w_op_a_nx;
      S_ENTER_B: w_disp_nx = (w_b_cnt_nx != 2'd0) ? w_op_b_nx : w_op_a_nx;
      S_SHOW:    w_disp_nx = w_result_nx;
      default:   w_disp_nx = r_disp;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_ENTER_A;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_result       <= '0;
      r_a_cnt        <= '0;
      r_b_cnt        <= '0;
      r_opcode       <= '0;
      r_cnt          <= '0;
      r_err          <= 1'b0;
      r_key_ready    <= 1'b1;
      r_alu_op       <= '0;
      r_assign_op1   <= 1'b0;
      r_assign_op2   <= 1'b0;
      r_alu_opcode   <= '0;
      r_alu_en       <= 1'b0;
      r_disp         <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_op_a         <= w_op_a_nx;
      r_op_b         <= w_op_b_nx;
      r_result       <= w_result_nx;
      r_a_cnt        <= w_a_cnt_nx;
      r_b_cnt        <= w_b_cnt_nx;
      r_opcode       <= w_opcode_nx;
      r_cnt          <= w_cnt_nx;
      r_err          <= w_err_nx;
      r_key_ready    <= w_key_ready_nx;
      r_alu_op       <= w_alu_op_nx;
      r_assign_op1   <= w_assign_op1_nx;
      r_assign_op2   <= w_assign_op2_nx;
      r_alu_opcode   <= w_alu_opcode_nx;
      r_alu_en       <= w_alu_en_nx;
      r_disp         <= w_disp_nx;
      r_result_valid <= w_result_valid_nx;
      r_busy         <= w_busy_nx;
    end
  end

  assign o_key_ready      = r_key_ready;
  assign o_alu_op         = r_alu_op;
  assign o_alu_assign_op1 = r_assign_op1;
  assign o_alu_assign_op2 = r_assign_op2;
  assign o_alu_opcode     = r_alu_opcode;
  assign o_alu_en         = r_alu_en;
  assign o_disp_value     = r_disp;
  assign o_result_valid   = r_result_valid;
  assign o_busy           = r_busy;
  assign o_err            = r_err;

endmodule
